// File: rtl/apb_spi_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : apb_spi_ctrl_pkg
// Brief    : Register offsets, register bit indices and sequencer state
//            encodings shared by the APB SPI controller.
// Revision : 1.0 - initial release
// ============================================================================
package apb_spi_ctrl_pkg;

    localparam int unsigned c_addr_txdata = 32'h0;
    localparam int unsigned c_addr_rxdata = 32'h4;
    localparam int unsigned c_addr_status = 32'h8;
    localparam int unsigned c_addr_ctrl   = 32'hC;

    localparam int unsigned c_st_tx_full  = 0;
    localparam int unsigned c_st_tx_empty = 1;
    localparam int unsigned c_st_rx_full  = 2;
    localparam int unsigned c_st_rx_empty = 3;
    localparam int unsigned c_st_busy     = 4;
    localparam int unsigned c_st_rx_ovf   = 5;

    localparam int unsigned c_ctrl_en    = 0;
    localparam int unsigned c_ctrl_ie_rx = 1;
    localparam int unsigned c_ctrl_ie_tx = 2;

    localparam logic [1:0] c_fsm_idle    = 2'd0;
    localparam logic [1:0] c_fsm_start   = 2'd1;
    localparam logic [1:0] c_fsm_wait_hi = 2'd2;
    localparam logic [1:0] c_fsm_wait_lo = 2'd3;

endpackage
`default_nettype wire

// File: rtl/apb_spi_ctrl_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module   : apb_spi_ctrl_sync_fifo
// Brief    : Single-clock FIFO; a full FIFO accepts a push only when it is
//            popped on the same cycle.
// Revision : 1.0 - initial release
// ============================================================================
module apb_spi_ctrl_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_data,
    input  logic                       i_pop,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [WIDTH-1:0]           o_head,
    output logic [$clog2(DEPTH):0]     o_count
);

    localparam int c_aw = $clog2(DEPTH);
    localparam int c_cw = c_aw + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_aw-1:0]  r_wr_ptr;
    logic [c_aw-1:0]  r_rd_ptr;
    logic [c_cw-1:0]  r_count;
    logic             w_pop_ok;
    logic             w_push_ok;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == c_cw'(DEPTH));
    assign o_head    = r_mem[r_rd_ptr];
    assign o_count   = r_count;
    assign w_pop_ok  = i_pop & ~o_empty;
    assign w_push_ok = i_push & (~o_full | w_pop_ok);

    always_ff @(posedge clk_i) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= r_count + c_cw'(w_push_ok) - c_cw'(w_pop_ok);
        end
    end

endmodule
`default_nettype wire

// File: rtl/apb_spi_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : apb_spi_ctrl
// Brief    : APB3 slave with TX/RX FIFOs and a frame sequencer driving an
//            8-bit CPOL=0/CPHA=0 SPI master.
// Revision : 1.0 - initial release
// ============================================================================
module apb_spi_ctrl
    import apb_spi_ctrl_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_W     = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              psel_i,
    input  logic              penable_i,
    input  logic              pwrite_i,
    input  logic [ADDR_W-1:0] paddr_bi,
    input  logic [31:0]       pwdata_bi,
    output logic [31:0]       prdata_bo,
    output logic              pready_o,
    output logic              pslverr_o,
    output logic              start_o,
    output logic [7:0]        tx_data_bo,
    input  logic              busy_i,
    input  logic [7:0]        rx_data_bi,
    output logic              irq_o
);

    localparam int c_cw = $clog2(FIFO_DEPTH) + 1;

    logic [1:0]      r_state;
    logic [1:0]      w_state_nxt;
    logic [2:0]      r_ctrl;
    logic            r_rx_ovf;
    logic [7:0]      r_tx_data;

    logic            w_access;
    logic            w_tx_push, w_tx_pop, w_tx_full, w_tx_empty;
    logic            w_rx_push, w_rx_pop, w_rx_full, w_rx_empty;
    logic [7:0]      w_tx_head, w_rx_head;
    logic [c_cw-1:0] w_tx_count, w_rx_count;
    logic            w_start;
    logic            w_ovf_clr, w_ctrl_we, w_err;
    logic [31:0]     w_rdata, w_status;
    logic            w_unused;

    assign w_unused = ^{pwdata_bi[31:8], pwdata_bi[4:3], w_tx_count, w_rx_count};
    assign w_access = psel_i & penable_i;

    apb_spi_ctrl_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .i_push  (w_tx_push),
        .i_data  (pwdata_bi[7:0]),
        .i_pop   (w_tx_pop),
        .o_full  (w_tx_full),
        .o_empty (w_tx_empty),
        .o_head  (w_tx_head),
        .o_count (w_tx_count)
    );

    apb_spi_ctrl_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .i_push  (w_rx_push),
        .i_data  (rx_data_bi),
        .i_pop   (w_rx_pop),
        .o_full  (w_rx_full),
        .o_empty (w_rx_empty),
        .o_head  (w_rx_head),
        .o_count (w_rx_count)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) r_state <= c_fsm_idle;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_fsm_idle:    if (r_ctrl[c_ctrl_en] && !w_tx_empty) w_state_nxt = c_fsm_start;
            c_fsm_start:   w_state_nxt = c_fsm_wait_hi;
            c_fsm_wait_hi: if (busy_i)  w_state_nxt = c_fsm_wait_lo;
            c_fsm_wait_lo: if (!busy_i) w_state_nxt = c_fsm_idle;
            default:       w_state_nxt = c_fsm_idle;
        endcase
    end

    always_comb begin
        w_tx_pop  = (r_state == c_fsm_idle) & r_ctrl[c_ctrl_en] & ~w_tx_empty;
        w_rx_push = (r_state == c_fsm_wait_lo) & ~busy_i;
        w_start   = (r_state == c_fsm_start);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i)         r_tx_data <= '0;
        else if (w_tx_pop) r_tx_data <= w_tx_head;
    end

    always_comb begin
        w_status                = '0;
        w_status[c_st_tx_full]  = w_tx_full;
        w_status[c_st_tx_empty] = w_tx_empty;
        w_status[c_st_rx_full]  = w_rx_full;
        w_status[c_st_rx_empty] = w_rx_empty;
        w_status[c_st_busy]     = (r_state != c_fsm_idle);
        w_status[c_st_rx_ovf]   = r_rx_ovf;
    end

    // Decode drives prdata/pslverr throughout the transfer; state only
    // changes on the access phase.
    always_comb begin
        w_rdata   = '0;
        w_err     = 1'b0;
        w_tx_push = 1'b0;
        w_rx_pop  = 1'b0;
        w_ovf_clr = 1'b0;
        w_ctrl_we = 1'b0;
        if (psel_i) begin
            if (paddr_bi == ADDR_W'(c_addr_txdata)) begin
                if (pwrite_i) begin
                    w_err     = w_tx_full & ~w_tx_pop;
                    w_tx_push = w_access & ~w_err;
                end else begin
                    w_err = 1'b1;
                end
            end else if (paddr_bi == ADDR_W'(c_addr_rxdata)) begin
                if (pwrite_i || w_rx_empty) begin
                    w_err = 1'b1;
                end else begin
                    w_rdata  = {24'b0, w_rx_head};
                    w_rx_pop = w_access;
                end
            end else if (paddr_bi == ADDR_W'(c_addr_status)) begin
                if (pwrite_i) w_ovf_clr = w_access & pwdata_bi[c_st_rx_ovf];
                else          w_rdata   = w_status;
            end else if (paddr_bi == ADDR_W'(c_addr_ctrl)) begin
                if (pwrite_i) w_ctrl_we = w_access;
                else          w_rdata   = {29'b0, r_ctrl};
            end else begin
                w_err = 1'b1;
            end
        end
    end

    // A fresh overflow wins over a simultaneous software clear.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_ctrl   <= '0;
            r_rx_ovf <= 1'b0;
        end else begin
            if (w_ctrl_we) r_ctrl <= pwdata_bi[2:0];
            if (w_rx_push && w_rx_full && !w_rx_pop) r_rx_ovf <= 1'b1;
            else if (w_ovf_clr)                      r_rx_ovf <= 1'b0;
        end
    end

    assign prdata_bo  = w_rdata;
    assign pslverr_o  = w_err;
    assign pready_o   = 1'b1;
    assign start_o    = w_start;
    assign tx_data_bo = r_tx_data;
    assign irq_o      = (~w_rx_empty & r_ctrl[c_ctrl_ie_rx]) | (w_tx_empty & r_ctrl[c_ctrl_ie_tx]);

endmodule
`default_nettype wire
